calendar_core: RTL and testbench
================================

CALENDAR_CORE -- requirements
Module: calendar_core

Interface
REQ-001 The block SHALL expose parameter RST_YEAR, default 0, meaning year-of-century (0..99) loaded at reset.
REQ-002 The block SHALL expose parameter RST_MONTH, default 1, meaning month (1..12) loaded at reset.
REQ-003 The block SHALL expose parameter RST_DAY, default 1, meaning day (1..31) loaded at reset.
REQ-004 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 tick_1hz  input  1  one-cycle strobe, one per second of elapsed time.
REQ-007 run  input  1  1 = timekeeping mode, 0 = set mode.
REQ-008 up_s, down_s, up_m, down_m, up_h, down_h, up_d, down_d, up_mo, down_mo, up_y, down_y  input  1 each  per-field adjust requests, level-held from the set-mode controller.
REQ-009 sec  output  6  seconds, 0..59.
REQ-010 min  output  6  minutes, 0..59.
REQ-011 hour  output  5  hours, 0..23.
REQ-012 day  output  5  day of month, 1..days_in_month.
REQ-013 month  output  4  month, 1..12.
REQ-014 year  output  7  year of century, 0..99 (0 = 2000).
REQ-015 century_wrap  output  1  one-cycle pulse when year rolls 99->0 by timekeeping.

Function
REQ-016 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-017 days_in_month SHALL be 31 for months 1,3,5,7,8,10,12, 30 for 4,6,9,11, and for month 2: 29 when year[1:0]==0, else 28.
REQ-018 Each of the 12 adjust inputs SHALL have a registered previous-value flop; an adjust event SHALL be cur & ~prev (rising edge), so a held level produces exactly one step.
REQ-019 Previous-value flops SHALL update every cycle regardless of run.
REQ-020 When run=1 and tick_1hz=1, the block SHALL advance one second at that clock edge: sec+1; at 59 -> 0 with carry to min; min 59 -> 0 carry to hour; hour 23 -> 0 carry to day; day==days_in_month -> 1 carry to month; month 12 -> 1 carry to year; year 99 -> 0.
REQ-021 The full cascade (e.g. 23:59:59 Dec 31 -> 00:00:00 Jan 1) SHALL complete on the single clock edge of the tick.
REQ-022 century_wrap SHALL be 1 for exactly the cycle after the edge where year wraps 99->0 via REQ-020, else 0.
REQ-023 When run=0, tick_1hz SHALL be ignored (time frozen).
REQ-024 When run=1, adjust events SHALL be ignored.
REQ-025 When run=0, an adjust event SHALL step only its field by +/-1 at that edge, wrapping within the field range and never carrying: sec/min 59<->0, hour 23<->0, day days_in_month<->1, month 12<->1, year 99<->0.
REQ-026 Simultaneous up and down events on the same field in one cycle SHALL leave that field unchanged.
REQ-027 Events on different fields in the same cycle SHALL all be applied at that edge.
REQ-028 After any month or year change (tick or adjust), day SHALL be clamped at that same edge to min(day, days_in_month of new month/year).
REQ-029 Day adjustment SHALL use days_in_month of the current (pre-edge) month/year.

Reset
REQ-030 On rst_n=0, asynchronously: sec=0, min=0, hour=0, day=RST_DAY, month=RST_MONTH, year=RST_YEAR, century_wrap=0, all previous-value flops=0.
REQ-031 An adjust input held high through reset release SHALL produce one step on the first edge after release if run=0.
REQ-032 Reset asserted mid-cascade SHALL override any pending update; no partial state survives.

Verification
REQ-033 run=1, state 23:59:59 Dec 31 year 99, one tick -> 00:00:00 Jan 1 year 0, century_wrap high one cycle.
REQ-034 run=1, Feb 28 year 4, 23:59:59, tick -> Feb 29; same with year 5 -> Mar 1.
REQ-035 run=0, up_m held high 10 cycles at min=59 -> min=0 after one edge, stays 0, hour unchanged.
REQ-036 run=0, Jan 31 year 1, up_mo rising -> month=2, day=28 on same edge.
REQ-037 run=0, up_s and down_s rise same cycle at sec=30 -> sec=30; tick_1hz pulses during run=0 -> no change.
REQ-038 Assert rst_n=0 mid-run with nonzero time -> outputs immediately 00:00:00, day=1, month=1, year=0.

Source files
------------

// File: rtl/calendar_core_if.sv
// Set-mode controls, the seconds strobe and the calendar outputs of calendar_core.
// The master side drives the controls; the slave side is the calendar itself.
interface calendar_core_if;
  logic       tick_1hz;
  logic       run;
  logic       up_s, down_s, up_m, down_m, up_h, down_h;
  logic       up_d, down_d, up_mo, down_mo, up_y, down_y;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       century_wrap;

  modport master (
    output tick_1hz, run,
    output up_s, down_s, up_m, down_m, up_h, down_h,
    output up_d, down_d, up_mo, down_mo, up_y, down_y,
    input  sec, min, hour, day, month, year, century_wrap
  );

  modport slave (
    input  tick_1hz, run,
    input  up_s, down_s, up_m, down_m, up_h, down_h,
    input  up_d, down_d, up_mo, down_mo, up_y, down_y,
    output sec, min, hour, day, month, year, century_wrap
  );
endinterface

// File: rtl/calendar_core.sv
// Time-of-day and calendar counter for years 2000-2099.
// It advances on a 1 Hz strobe and, in set mode, steps single fields on rising edges of the adjust inputs.
module calendar_core #(
  parameter int RST_YEAR  = 0,
  parameter int RST_MONTH = 1,
  parameter int RST_DAY   = 1
) (
  input logic            clk_in,
  input logic            rst_n,
  calendar_core_if.slave bus
);

  logic [5:0]  sec_reg, sec_next, min_reg, min_next;
  logic [4:0]  hour_reg, hour_next, day_reg, day_next;
  logic [3:0]  month_reg, month_next;
  logic [6:0]  year_reg, year_next;
  logic        wrap_reg, wrap_next;
  logic [11:0] adj_cur, adj_prev_reg, adj_ev;
  logic [5:0]  inc, dec;
  logic [4:0]  dim_cur, dim_new;

  // Field f (0=sec .. 5=year) has its up request at bit 2f+1 and its down request at bit 2f.
  assign adj_cur = {bus.up_y, bus.down_y, bus.up_mo, bus.down_mo, bus.up_d, bus.down_d,
                    bus.up_h, bus.down_h, bus.up_m, bus.down_m, bus.up_s, bus.down_s};

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_edge
      assign adj_ev[gi] = adj_cur[gi] & ~adj_prev_reg[gi];
    end
    for (gi = 0; gi < 6; gi++) begin : g_dir
      assign inc[gi] = adj_ev[2*gi+1] & ~adj_ev[2*gi];
      assign dec[gi] = adj_ev[2*gi]   & ~adj_ev[2*gi+1];
    end
  endgenerate

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [1:0] y_low);
    case (m)
      4'd2:                      days_in_month = (y_low == 2'd0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   days_in_month = 5'd30;
      default:                   days_in_month = 5'd31;
    endcase
  endfunction

  function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] lo,
                                           input logic [6:0] hi, input logic up, input logic dn);
    if (up)      wrap_step = (v == hi) ? lo : v + 7'd1;
    else if (dn) wrap_step = (v == lo) ? hi : v - 7'd1;
    else         wrap_step = v;
  endfunction

  assign dim_cur = days_in_month(month_reg, year_reg[1:0]);
  assign dim_new = days_in_month(month_next, year_next[1:0]);

  always_comb begin
    sec_next   = sec_reg;
    min_next   = min_reg;
    hour_next  = hour_reg;
    day_next   = day_reg;
    month_next = month_reg;
    year_next  = year_reg;
    wrap_next  = 1'b0;
    if (bus.run) begin
      if (bus.tick_1hz) begin
        if (sec_reg == 6'd59) begin
          sec_next = 6'd0;
          if (min_reg == 6'd59) begin
            min_next = 6'd0;
            if (hour_reg == 5'd23) begin
              hour_next = 5'd0;
              if (day_reg >= dim_cur) begin
                day_next = 5'd1;
                if (month_reg == 4'd12) begin
                  month_next = 4'd1;
                  if (year_reg == 7'd99) begin
                    year_next = 7'd0;
                    wrap_next = 1'b1;
                  end else begin
                    year_next = year_reg + 7'd1;
                  end
                end else begin
                  month_next = month_reg + 4'd1;
                end
              end else begin
                day_next = day_reg + 5'd1;
              end
            end else begin
              hour_next = hour_reg + 5'd1;
            end
          end else begin
            min_next = min_reg + 6'd1;
          end
        end else begin
          sec_next = sec_reg + 6'd1;
        end
      end
    end else begin
      sec_next   = 6'(wrap_step({1'b0, sec_reg}, 7'd0, 7'd59, inc[0], dec[0]));
      min_next   = 6'(wrap_step({1'b0, min_reg}, 7'd0, 7'd59, inc[1], dec[1]));
      hour_next  = 5'(wrap_step({2'b0, hour_reg}, 7'd0, 7'd23, inc[2], dec[2]));
      day_next   = 5'(wrap_step({2'b0, day_reg}, 7'd1, {2'b0, dim_cur}, inc[3], dec[3]));
      month_next = 4'(wrap_step({3'b0, month_reg}, 7'd1, 7'd12, inc[4], dec[4]));
      year_next  = wrap_step(year_reg, 7'd0, 7'd99, inc[5], dec[5]);
    end
    // A month or year change can leave the day past the end of the new month.
    if (day_next > dim_new)
      day_next = dim_new;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sec_reg      <= 6'd0;
      min_reg      <= 6'd0;
      hour_reg     <= 5'd0;
      day_reg      <= 5'(RST_DAY);
      month_reg    <= 4'(RST_MONTH);
      year_reg     <= 7'(RST_YEAR);
      wrap_reg     <= 1'b0;
      adj_prev_reg <= 12'd0;
    end else begin
      sec_reg      <= sec_next;
      min_reg      <= min_next;
      hour_reg     <= hour_next;
      day_reg      <= day_next;
      month_reg    <= month_next;
      year_reg     <= year_next;
      wrap_reg     <= wrap_next;
      adj_prev_reg <= adj_cur;
    end
  end

  assign bus.sec          = sec_reg;
  assign bus.min          = min_reg;
  assign bus.hour         = hour_reg;
  assign bus.day          = day_reg;
  assign bus.month        = month_reg;
  assign bus.year         = year_reg;
  assign bus.century_wrap = wrap_reg;

endmodule

// File: tb/tb_calendar_core.sv
// Scoreboard bench for calendar_core: directed stimulus pushes hand-computed states,
// and a monitor compares them one clock edge later.
module tb_calendar_core;

  localparam logic [11:0] DS = 12'h001, US = 12'h002, DM = 12'h004, UM = 12'h008;
  localparam logic [11:0] DH = 12'h010, UH = 12'h020, DD = 12'h040, UD = 12'h080;
  localparam logic [11:0] DMO = 12'h100, UMO = 12'h200, DY = 12'h400, UY = 12'h800;

  typedef struct {
    string nm;
    int s, mi, h, d, mo, y, cw;
  } exp_t;

  logic clk_in;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  calendar_core_if bus();

  calendar_core #(.RST_YEAR(0), .RST_MONTH(1), .RST_DAY(1)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string nm, input string fld, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endtask

  task automatic compare_state(input exp_t e);
    chk(e.nm, "sec",   int'(bus.sec),          e.s);
    chk(e.nm, "min",   int'(bus.min),          e.mi);
    chk(e.nm, "hour",  int'(bus.hour),         e.h);
    chk(e.nm, "day",   int'(bus.day),          e.d);
    chk(e.nm, "month", int'(bus.month),        e.mo);
    chk(e.nm, "year",  int'(bus.year),         e.y);
    chk(e.nm, "cwrap", int'(bus.century_wrap), e.cw);
    $display("txn %-14s %02d:%02d:%02d %02d/%02d/%02d cw=%0d", e.nm, bus.hour, bus.min, bus.sec,
             bus.day, bus.month, bus.year, bus.century_wrap);
  endtask

  task automatic set_adj(input logic [11:0] a);
    {bus.up_y, bus.down_y, bus.up_mo, bus.down_mo, bus.up_d, bus.down_d,
     bus.up_h, bus.down_h, bus.up_m, bus.down_m, bus.up_s, bus.down_s} = a;
  endtask

  task automatic push_exp(input string nm, input int s, input int mi, input int h,
                          input int d, input int mo, input int y, input int cw);
    exp_t e;
    e.nm = nm; e.s = s; e.mi = mi; e.h = h; e.d = d; e.mo = mo; e.y = y; e.cw = cw;
    exp_q.push_back(e);
  endtask

  // Inputs change just after a falling edge; the expectation is the state after the next rising edge.
  task automatic drive(input string nm, input logic r, input logic t, input logic [11:0] a,
                       input int s, input int mi, input int h, input int d,
                       input int mo, input int y, input int cw);
    @(negedge clk_in);
    #2;
    bus.run      = r;
    bus.tick_1hz = t;
    set_adj(a);
    push_exp(nm, s, mi, h, d, mo, y, cw);
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) compare_state(exp_q.pop_front());
    end
  end

  initial begin
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.run  = 1'b0;
    bus.tick_1hz = 1'b0;
    set_adj(12'd0);
    @(negedge clk_in);
    #2;
    e.nm = "in_reset"; e.s = 0; e.mi = 0; e.h = 0; e.d = 1; e.mo = 1; e.y = 0; e.cw = 0;
    compare_state(e);
    @(negedge clk_in);
    #2;
    rst_n = 1'b1;

    drive("idle",      0, 0, 12'd0, 0, 0, 0, 1, 1, 0, 0);
    // All fields stepped down together from the reset date: 23:59:59 Dec 31, year 99.
    drive("set_dec31", 0, 0, DS|DM|DH|DD|DMO|DY, 59, 59, 23, 31, 12, 99, 0);
    drive("hold_dec31", 0, 0, 12'd0, 59, 59, 23, 31, 12, 99, 0);
    drive("century",   1, 1, 12'd0, 0, 0, 0, 1, 1, 0, 1);
    drive("cwrap_drop", 1, 0, 12'd0, 0, 0, 0, 1, 1, 0, 0);

    // Day stepped with January's length, then clamped to February of year 1.
    drive("set_feb",   0, 0, DS|DM|DH|DD|UMO|UY, 59, 59, 23, 28, 2, 1, 0);
    drive("rel",       0, 0, 12'd0, 59, 59, 23, 28, 2, 1, 0);
    for (int i = 2; i <= 4; i++) begin
      drive("year_up", 0, 0, UY,    59, 59, 23, 28, 2, i, 0);
      drive("rel",     0, 0, 12'd0, 59, 59, 23, 28, 2, i, 0);
    end
    drive("leap_tick", 1, 1, 12'd0, 0, 0, 0, 29, 2, 4, 0);
    drive("clamp_y5",  0, 0, DS|DM|DH|UY, 59, 59, 23, 28, 2, 5, 0);
    drive("rel",       0, 0, 12'd0, 59, 59, 23, 28, 2, 5, 0);
    drive("nonleap",   1, 1, 12'd0, 0, 0, 0, 1, 3, 5, 0);

    drive("min_59",    0, 0, DM, 0, 59, 0, 1, 3, 5, 0);
    for (int i = 0; i < 10; i++)
      drive("up_m_held", 0, 0, UM, 0, 0, 0, 1, 3, 5, 0);
    drive("rel",       0, 0, 12'd0, 0, 0, 0, 1, 3, 5, 0);

    drive("mo_y_dn",   0, 0, DMO|DY, 0, 0, 0, 1, 2, 4, 0);
    drive("rel",       0, 0, 12'd0,  0, 0, 0, 1, 2, 4, 0);
    drive("mo_y_dn",   0, 0, DMO|DY, 0, 0, 0, 1, 1, 3, 0);
    drive("rel",       0, 0, 12'd0,  0, 0, 0, 1, 1, 3, 0);
    drive("y_dn",      0, 0, DY,     0, 0, 0, 1, 1, 2, 0);
    drive("rel",       0, 0, 12'd0,  0, 0, 0, 1, 1, 2, 0);
    drive("jan31",     0, 0, DY|DD,  0, 0, 0, 31, 1, 1, 0);
    drive("rel",       0, 0, 12'd0,  0, 0, 0, 31, 1, 1, 0);
    drive("mo_clamp",  0, 0, UMO,    0, 0, 0, 28, 2, 1, 0);
    drive("rel",       0, 0, 12'd0,  0, 0, 0, 28, 2, 1, 0);

    for (int i = 1; i <= 30; i++) begin
      drive("sec_up",  0, 0, US,    i, 0, 0, 28, 2, 1, 0);
      drive("rel",     0, 0, 12'd0, i, 0, 0, 28, 2, 1, 0);
    end
    drive("up_dn_s",   0, 0, US|DS, 30, 0, 0, 28, 2, 1, 0);
    drive("rel",       0, 0, 12'd0, 30, 0, 0, 28, 2, 1, 0);
    for (int i = 0; i < 3; i++)
      drive("frozen",  0, 1, 12'd0, 30, 0, 0, 28, 2, 1, 0);

    drive("run_adj",   1, 0, UH,    30, 0, 0, 28, 2, 1, 0);
    drive("held_adj",  0, 0, UH,    30, 0, 0, 28, 2, 1, 0);
    drive("rel",       0, 0, 12'd0, 30, 0, 0, 28, 2, 1, 0);
    drive("multi",     0, 0, US|UM|UH, 31, 1, 1, 28, 2, 1, 0);
    drive("rel",       0, 0, 12'd0, 31, 1, 1, 28, 2, 1, 0);
    drive("run_tick",  1, 1, 12'd0, 32, 1, 1, 28, 2, 1, 0);
    drive("run_idle",  1, 0, 12'd0, 32, 1, 1, 28, 2, 1, 0);

    // Reset in the middle of running, with an adjust request held across release.
    @(negedge clk_in);
    #2;
    bus.tick_1hz = 1'b1;
    rst_n = 1'b0;
    #1;
    e.nm = "async_rst"; e.s = 0; e.mi = 0; e.h = 0; e.d = 1; e.mo = 1; e.y = 0; e.cw = 0;
    compare_state(e);
    bus.run = 1'b0;
    bus.tick_1hz = 1'b0;
    set_adj(US);
    @(negedge clk_in);
    #2;
    rst_n = 1'b1;
    push_exp("rst_held_s", 1, 0, 0, 1, 1, 0, 0);
    drive("still_held", 0, 0, US,    1, 0, 0, 1, 1, 0, 0);
    drive("rel",        0, 0, 12'd0, 1, 0, 0, 1, 1, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_in);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
